// File: rtl/spm_driver_if.sv
// Operand/result handshake plus the serial link to an attached spm multiplier.
// master = bus/spm side, slave = spm_driver.
interface spm_driver_if #(
    parameter int BITS = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [BITS-1:0]     in_a;
    logic [BITS-1:0]     in_x;
    logic                out_valid;
    logic                out_ready;
    logic [2*BITS-1:0]   out_p;
    logic                spm_rst_n;
    logic                spm_x;
    logic [BITS-1:0]     spm_a;
    logic                spm_y;

    modport slave (
        input  in_valid, in_a, in_x, out_ready, spm_y,
        output in_ready, out_valid, out_p, spm_rst_n, spm_x, spm_a
    );

    modport master (
        output in_valid, in_a, in_x, out_ready, spm_y,
        input  in_ready, out_valid, out_p, spm_rst_n, spm_x, spm_a
    );
endinterface

// File: rtl/spm_driver.sv
// Sequencer for a bit-serial unsigned spm multiplier: loads a/x, streams x
// LSB-first with zero flush, and gathers the serial product into one word.
module spm_driver #(
    parameter int BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    spm_driver_if.slave  bus
);
    localparam int PW = 2 * BITS;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] LAST = CW'(PW);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t          state;
    logic [BITS-1:0] a_reg;
    logic [PW-1:0]   x_sh;
    logic [PW-1:0]   p_sh;
    logic [PW-1:0]   p_reg;
    logic [CW-1:0]   cnt;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            spm_rst_n_r;
    logic            spm_x_r;
    logic [PW-1:0]   p_next;

    // spm_y in RUN cycle c carries product bit c-1, so bits shift in from the top
    assign p_next = {bus.spm_y, p_sh[PW-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            x_sh        <= '0;
            p_sh        <= '0;
            p_reg       <= '0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            spm_rst_n_r <= 1'b0;
            spm_x_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg       <= bus.in_a;
                        x_sh        <= {{BITS{1'b0}}, bus.in_x};
                        p_sh        <= '0;
                        cnt         <= '0;
                        in_ready_r  <= 1'b0;
                        spm_rst_n_r <= 1'b1;
                        state       <= ARM;
                    end
                end
                ARM: begin
                    // spm_x is registered, so the first bit is staged here for RUN c=0
                    spm_x_r <= x_sh[0];
                    x_sh    <= x_sh >> 1;
                    state   <= RUN;
                end
                RUN: begin
                    if (cnt != '0)
                        p_sh <= p_next;
                    if (cnt == LAST) begin
                        p_reg       <= p_next;
                        out_valid_r <= 1'b1;
                        spm_x_r     <= 1'b0;
                        state       <= DONE;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        spm_x_r <= x_sh[0];
                        x_sh    <= x_sh >> 1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        spm_rst_n_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_p     = p_reg;
    assign bus.spm_rst_n = spm_rst_n_r;
    assign bus.spm_x     = spm_x_r;
    assign bus.spm_a     = a_reg;
endmodule

// File: tb/tb_spm_driver.sv
// Bench for spm_driver: behavioural spm attached, results compared against a*x.
module tb_spm_driver;
    localparam int BITS = 32;
    localparam int PW   = 2 * BITS;
    localparam int LAT  = 2 * BITS + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spm_driver_if #(.BITS(BITS)) bus ();

    spm_driver #(.BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural serial/parallel multiplier: a shift-right accumulator that emits
    // one settled product bit per cycle, one cycle after the matching x bit.
    logic [BITS:0] spm_acc;
    logic [BITS:0] spm_sum;
    logic          spm_y_r;
    assign spm_sum = spm_acc + (bus.spm_x ? {1'b0, bus.spm_a} : '0);
    assign bus.spm_y = spm_y_r;
    always_ff @(posedge clk) begin
        if (!bus.spm_rst_n) begin
            spm_acc <= '0;
            spm_y_r <= 1'b0;
        end else begin
            spm_acc <= spm_sum >> 1;
            spm_y_r <= spm_sum[0];
        end
    end

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; stall = cycles out_ready stays low once the product is up
    // (stall 0 means out_ready is already high from acceptance onward).
    task automatic run_op(input logic [BITS-1:0] a, input logic [BITS-1:0] x, input int stall);
        int            cyc;
        int            c;
        logic          exp_x;
        logic          busy_ok;
        logic          x_ok;
        logic          a_ok;
        logic          stable_ok;
        logic [PW-1:0] exp_p;
        exp_p = PW'(a) * PW'(x);
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 10) begin
            tick();
            cyc++;
        end
        check("in_ready_idle", PW'(bus.in_ready), PW'(1));
        bus.in_a      = a;
        bus.in_x      = x;
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        tick();
        bus.in_valid = 1'b0;
        cyc     = 1;
        busy_ok = 1'b1;
        x_ok    = 1'b1;
        a_ok    = 1'b1;
        // cycle 1 is the arm cycle, cycle 2+c is RUN step c
        while (bus.out_valid !== 1'b1 && cyc < LAT + 20) begin
            if (bus.in_ready !== 1'b0 || bus.spm_rst_n !== 1'b1) busy_ok = 1'b0;
            c = cyc - 2;
            exp_x = (c >= 0 && c < BITS) ? x[c] : 1'b0;
            if (bus.spm_x !== exp_x) x_ok = 1'b0;
            if (bus.spm_a !== a) a_ok = 1'b0;
            bus.in_a     = $urandom;
            bus.in_x     = $urandom;
            bus.in_valid = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("latency", PW'(cyc), PW'(LAT));
        check("busy_in_ready_low", PW'(busy_ok), PW'(1));
        check("spm_x_serial", PW'(x_ok), PW'(1));
        check("spm_a_hold", PW'(a_ok), PW'(1));
        check("product", bus.out_p, exp_p);
        if (bus.out_valid !== 1'b1) return;
        stable_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_p !== exp_p || bus.in_ready !== 1'b0)
                stable_ok = 1'b0;
        end
        if (stall > 0) check("backpressure_hold", PW'(stable_ok), PW'(1));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("handshake_drop", PW'({bus.out_valid, bus.in_ready}), PW'(2'b01));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_x      = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_in_ready", PW'(bus.in_ready), PW'(1));
        check("reset_out_valid", PW'(bus.out_valid), PW'(0));
        check("reset_out_p", bus.out_p, '0);
        check("reset_spm_ctrl", PW'({bus.spm_rst_n, bus.spm_x}), PW'(0));
        check("reset_spm_a", PW'(bus.spm_a), PW'(0));

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h0, 32'h1234_5678, 1);
        run_op(32'd3, 32'd5, 0);
        run_op(32'd7, 32'd9, 0);
        run_op(32'hDEAD_BEEF, 32'hCAFE_F00D, 20);
        run_op(32'h1, 32'hFFFF_FFFF, 2);

        // abort in RUN step c=10
        bus.in_a     = 32'h1357_9BDF;
        bus.in_x     = 32'h2468_ACE0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", PW'(bus.out_valid), PW'(0));
        check("abort_out_p", bus.out_p, '0);
        check("abort_spm_rst_n", PW'(bus.spm_rst_n), PW'(0));
        check("abort_in_ready", PW'(bus.in_ready), PW'(1));
        run_op(32'd6, 32'd7, 0);

        for (int k = 0; k < 6; k++)
            run_op($urandom, $urandom, int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
